// File: rtl/demo_streaming_mem_arbiter_if.sv
// Avalon-style memory master port bundle shared by the DMA and CPU masters.
// Latency: none (wires only).
// Backpressure: waitrequest from the arbiter holds the master's request in place.
//
// Signals:
//   address/byteenable/read/write/writedata : master -> arbiter request fields
//   waitrequest                             : arbiter -> master, high = not accepted
//   readdata/readdatavalid                  : arbiter -> master read return
interface demo_streaming_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  // Master side drives requests and observes the handshake/return.
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  // Arbiter side observes requests and drives the handshake/return.
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/demo_streaming_mem_arbiter.sv
// Two-master round-robin arbiter (m0 = streaming DMA, m1 = CPU) for a single-port on-chip RAM.
// Latency: request accepted in the cycle it is granted; read data returns exactly 1 cycle after accept.
// Backpressure: losing master sees waitrequest=1 and must hold its request; tenure capped at BURST_MAX accepts under contention.
//
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   m0, m1            : master ports (demo_streaming_mem_arbiter_if.slave)
//   mem_*             : RAM port (registered address inside RAM, unregistered q)
//   mem_readdata      : RAM read data, valid the cycle after a read is issued
// Optional build macro DEMO_MEM_ARB_PERF_EN adds:
//   perf_clr          : synchronous clear of the performance counters
//   perf_grant0/1     : accepted transfers per master (wrap at 2^32)
//   perf_contend      : cycles in which at least one request was held off
module demo_streaming_mem_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 5120,
  parameter int BURST_MAX = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  demo_streaming_mem_arbiter_if.slave m0,
  demo_streaming_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
`ifdef DEMO_MEM_ARB_PERF_EN
  ,
  input  logic                perf_clr,
  output logic [31:0]         perf_grant0,
  output logic [31:0]         perf_grant1,
  output logic [31:0]         perf_contend
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]  LP_DEPTH     = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LP_BURST_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] LP_CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } owner_t;

  // Arbitration state
  owner_t             r_owner;
  logic               r_last_owner;   // 1 = m1 held the bus most recently
  logic [CNT_W-1:0]   r_burst_cnt;

  // Read return tracking
  logic               r_rd_pend;
  logic               r_rd_tag;       // which master the pending return belongs to
  logic               r_rd_oor;       // pending read was out of range: return zero

  // Combinational arbitration / datapath
  logic               w_req0;
  logic               w_req1;
  logic               w_burst_full;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_acc;
  owner_t             w_next_owner;
  logic [ADDR_W-1:0]  w_addr;
  logic [BE_W-1:0]    w_be;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_is_write;
  logic               w_in_range;
  logic               w_rd_acc;
  logic               w_rdv0;
  logic               w_rdv1;

  assign w_req0       = m0.read | m0.write;
  assign w_req1       = m1.read | m1.write;
  assign w_burst_full = (r_burst_cnt == LP_BURST_MAX);

  // Grant decision. The current owner keeps the bus unless it has used up its
  // tenure while the other master is waiting; an idle bus alternates based on
  // who owned it last so that neither master can starve the other.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_owner)
      ST_OWN0: begin
        if (w_req0 && !(w_burst_full && w_req1)) w_gnt0 = 1'b1;
        else if (w_req1)                         w_gnt1 = 1'b1;
      end
      ST_OWN1: begin
        if (w_req1 && !(w_burst_full && w_req0)) w_gnt1 = 1'b1;
        else if (w_req0)                         w_gnt0 = 1'b1;
      end
      default: begin
        if (w_req0 && w_req1) begin
          w_gnt0 = r_last_owner;
          w_gnt1 = !r_last_owner;
        end else begin
          w_gnt0 = w_req0;
          w_gnt1 = w_req1;
        end
      end
    endcase
    // Nothing may be accepted while reset is held, even though the owner
    // state already reads NONE.
    if (!reset_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  always_comb begin
    w_next_owner = ST_NONE;
    if (w_gnt0)      w_next_owner = ST_OWN0;
    else if (w_gnt1) w_next_owner = ST_OWN1;
  end

  // Grants are only ever issued to a requesting master, so grant == accept.
  assign w_acc = (w_gnt0 && w_req0) || (w_gnt1 && w_req1);

  // Datapath mux: m1 fields only when m1 is granted, m0 otherwise.
  assign w_addr     = w_gnt1 ? m1.address    : m0.address;
  assign w_be       = w_gnt1 ? m1.byteenable : m0.byteenable;
  assign w_wdata    = w_gnt1 ? m1.writedata  : m0.writedata;
  // read+write together is a write.
  assign w_is_write = w_gnt1 ? m1.write      : m0.write;
  assign w_in_range = ({1'b0, w_addr} < LP_DEPTH);
  assign w_rd_acc   = w_acc && !w_is_write;

  assign mem_address    = w_addr;
  assign mem_byteenable = w_be;
  assign mem_writedata  = w_wdata;
  assign mem_chipselect = w_acc && w_in_range;
  // Out-of-range writes never reach the RAM and are otherwise acknowledged normally.
  assign mem_write      = w_acc && w_in_range && w_is_write;
  assign mem_clken      = 1'b1;

  assign m0.waitrequest = !w_gnt0;
  assign m1.waitrequest = !w_gnt1;

  // Owner FSM, tenure counter and read-return pipeline stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner      <= ST_NONE;
      r_last_owner <= 1'b1;
      r_burst_cnt  <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_tag     <= 1'b0;
      r_rd_oor     <= 1'b0;
    end else begin
      r_owner <= w_next_owner;
      if (w_next_owner != r_owner) begin
        // The transfer that wins the new tenure is its first accept.
        r_burst_cnt <= LP_CNT_ONE;
        if (w_next_owner == ST_OWN0)      r_last_owner <= 1'b0;
        else if (w_next_owner == ST_OWN1) r_last_owner <= 1'b1;
      end else if (w_acc && !w_burst_full) begin
        r_burst_cnt <= r_burst_cnt + LP_CNT_ONE;
      end
      r_rd_pend <= w_rd_acc;
      r_rd_tag  <= w_gnt1;
      r_rd_oor  <= !w_in_range;
    end
  end

  assign w_rdv0 = r_rd_pend && !r_rd_tag;
  assign w_rdv1 = r_rd_pend &&  r_rd_tag;

  assign m0.readdatavalid = w_rdv0;
  assign m1.readdatavalid = w_rdv1;
  // Out-of-range reads return zero; otherwise the RAM q passes straight through.
  assign m0.readdata = (w_rdv0 && r_rd_oor) ? '0 : mem_readdata;
  assign m1.readdata = (w_rdv1 && r_rd_oor) ? '0 : mem_readdata;

`ifdef DEMO_MEM_ARB_PERF_EN
  logic r_unused_perf;
  logic w_contend;

  assign w_contend = (w_req0 && !w_gnt0) || (w_req1 && !w_gnt1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_grant0  <= '0;
      perf_grant1  <= '0;
      perf_contend <= '0;
    end else if (perf_clr) begin
      perf_grant0  <= '0;
      perf_grant1  <= '0;
      perf_contend <= '0;
    end else begin
      if (w_gnt0 && w_req0) perf_grant0  <= perf_grant0 + 32'd1;
      if (w_gnt1 && w_req1) perf_grant1  <= perf_grant1 + 32'd1;
      if (w_contend)        perf_contend <= perf_contend + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demo_streaming_mem_arbiter.sv
// Self-checking bench for demo_streaming_mem_arbiter: directed scenarios plus a
// randomized two-master run checked against a run-length arbitration model and
// a shadow copy of memory.
module tb_demo_streaming_mem_arbiter;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 5120;
  localparam int BURST_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  demo_streaming_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  demo_streaming_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;

`ifdef DEMO_MEM_ARB_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_grant0, perf_grant1, perf_contend;
`endif

  demo_streaming_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .m0(m0_if),
    .m1(m1_if),
    .mem_address(mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
`ifdef DEMO_MEM_ARB_PERF_EN
    ,
    .perf_clr(perf_clr),
    .perf_grant0(perf_grant0),
    .perf_grant1(perf_grant1),
    .perf_contend(perf_contend)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // RAM model: registered address, combinational q, byte-lane writes.
  logic [31:0]       ram    [0:8191];
  logic [31:0]       shadow [0:8191];
  logic [ADDR_W-1:0] ram_addr = '0;

  always @(posedge clk) begin
    if (mem_chipselect) begin
      ram_addr <= mem_address;
      if (mem_write) ram[mem_address] <= merge_be(ram[mem_address], mem_writedata, mem_byteenable);
    end
  end
  assign mem_readdata = ram[ram_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drive(input int n, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (n == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.writedata = d; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.writedata = d; m1_if.byteenable = be;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 1'b1, 1'b1, 13'h0010, 32'h1, 4'hF);
    drive(1, 1'b1, 1'b1, 13'h0020, 32'h2, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait0: got %b exp 1", m0_if.waitrequest); end
    checks++; if (m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait1: got %b exp 1", m1_if.waitrequest); end
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b exp 0", mem_chipselect); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", mem_write); end
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv0: got %b exp 0", m0_if.readdatavalid); end
    checks++; if (m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv1: got %b exp 0", m1_if.readdatavalid); end
    idle_all();
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    drive(0, 1'b0, 1'b1, 13'h0010, 32'hA5A5_0001, 4'hF);
    @(negedge clk);
    checks++; if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL wr_wait0: got %b exp 0", m0_if.waitrequest); end
    checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL wr_cs_we: got %b%b exp 11", mem_chipselect, mem_write); end
    checks++; if (mem_address !== 13'h0010) begin errors++; $display("FAIL wr_addr: got %h exp 0010", mem_address); end
    next_cycle();
    shadow[16] = 32'hA5A5_0001;
    drive(0, 1'b1, 1'b0, 13'h0010, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL rd_cs_we: got %b%b exp 10", mem_chipselect, mem_write); end
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_early_rdv0: got %b exp 0", m0_if.readdatavalid); end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++; if (m0_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL rd_rdv0: got %b exp 1", m0_if.readdatavalid); end
    checks++; if (m0_if.readdata !== 32'hA5A5_0001) begin errors++; $display("FAIL rd_data0: got %h exp a5a50001", m0_if.readdata); end
    checks++; if (m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_rdv1: got %b exp 0", m1_if.readdatavalid); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int cnt [2];
    int prev_w;
    logic [ADDR_W-1:0] prev_a;
    logic [ADDR_W-1:0] a [2];
    int w;
    cnt[0] = 0; cnt[1] = 0; prev_w = -1; prev_a = '0;
    do_reset();
    for (int i = 0; i < 48; i++) begin
      for (int n = 0; n < 2; n++) begin
        a[n] = 13'(32'h200 + n * 32'h40 + cnt[n]);
        drive(n, 1'b1, 1'b0, a[n], 32'h0, 4'hF);
      end
      w = (i / BURST_MAX) % 2;
      @(negedge clk);
      checks++; if (m0_if.waitrequest !== (w != 0)) begin errors++; $display("FAIL rr_wait0 cyc%0d: got %b exp %b", i, m0_if.waitrequest, w != 0); end
      checks++; if (m1_if.waitrequest !== (w != 1)) begin errors++; $display("FAIL rr_wait1 cyc%0d: got %b exp %b", i, m1_if.waitrequest, w != 1); end
      checks++; if (mem_chipselect !== 1'b1) begin errors++; $display("FAIL rr_cs cyc%0d: got %b exp 1", i, mem_chipselect); end
      if (prev_w >= 0) begin
        checks++;
        if ((prev_w == 0 ? m0_if.readdatavalid : m1_if.readdatavalid) !== 1'b1 ||
            (prev_w == 0 ? m1_if.readdatavalid : m0_if.readdatavalid) !== 1'b0) begin
          errors++; $display("FAIL rr_rdv cyc%0d: got %b%b exp owner m%0d", i, m1_if.readdatavalid, m0_if.readdatavalid, prev_w);
        end
        checks++;
        if ((prev_w == 0 ? m0_if.readdata : m1_if.readdata) !== shadow[prev_a]) begin
          errors++; $display("FAIL rr_data cyc%0d: got %h exp %h", i, (prev_w == 0 ? m0_if.readdata : m1_if.readdata), shadow[prev_a]);
        end
      end
      prev_w = w; prev_a = a[w]; cnt[w]++;
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    checks++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== shadow[prev_a]) begin errors++; $display("FAIL rr_last: got %b/%h exp 1/%h", m1_if.readdatavalid, m1_if.readdata, shadow[prev_a]); end
    next_cycle();
  endtask

  task automatic test_out_of_range();
    drive(1, 1'b0, 1'b1, 13'h1400, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    checks++; if (m1_if.waitrequest !== 1'b0) begin errors++; $display("FAIL oor_wr_wait1: got %b exp 0", m1_if.waitrequest); end
    checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL oor_wr_cs_we: got %b%b exp 00", mem_chipselect, mem_write); end
    next_cycle();
    drive(1, 1'b1, 1'b0, 13'h1400, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (m1_if.waitrequest !== 1'b0) begin errors++; $display("FAIL oor_rd_wait1: got %b exp 0", m1_if.waitrequest); end
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL oor_rd_cs: got %b exp 0", mem_chipselect); end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++; if (m1_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL oor_rdv1: got %b exp 1", m1_if.readdatavalid); end
    checks++; if (m1_if.readdata !== 32'h0) begin errors++; $display("FAIL oor_data1: got %h exp 00000000", m1_if.readdata); end
    next_cycle();
  endtask

  task automatic test_byte_write();
    drive(1, 1'b0, 1'b1, 13'h0020, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    checks++; if (m1_if.waitrequest !== 1'b0) begin errors++; $display("FAIL bw_fill_wait1: got %b exp 0", m1_if.waitrequest); end
    next_cycle();
    drive(1, 1'b0, 1'b1, 13'h0020, 32'h1122_3344, 4'h3);
    @(negedge clk);
    checks++; if (mem_byteenable !== 4'h3 || mem_write !== 1'b1) begin errors++; $display("FAIL bw_be: got %h/%b exp 3/1", mem_byteenable, mem_write); end
    next_cycle();
    drive(1, 1'b1, 1'b0, 13'h0020, 32'h0, 4'hF);
    next_cycle();
    idle_all();
    shadow[32] = 32'hFFFF_3344;
    @(negedge clk);
    checks++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'hFFFF_3344) begin errors++; $display("FAIL bw_data: got %b/%h exp 1/ffff3344", m1_if.readdatavalid, m1_if.readdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    drive(0, 1'b1, 1'b0, 13'h0010, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL mr_wait0: got %b exp 0", m0_if.waitrequest); end
    next_cycle();
    reset_n = 1'b0;
    idle_all();
    @(negedge clk);
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL mr_rdv0_in_reset: got %b exp 0", m0_if.readdatavalid); end
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL mr_rdv0_after: got %b exp 0", m0_if.readdatavalid); end
    next_cycle();
    drive(0, 1'b1, 1'b0, 13'h0010, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 13'h0020, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL mr_first_win: got wait %b%b exp m1=1 m0=0", m1_if.waitrequest, m0_if.waitrequest); end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  // Randomized contention: each master holds a request until the model says it
  // was accepted. Arbitration model: winner of the last cycle and its run length.
  task automatic test_random();
    logic              act [2];
    logic              rd  [2];
    logic              wr  [2];
    logic [ADDR_W-1:0] ad  [2];
    logic [31:0]       dt  [2];
    logic [3:0]        be  [2];
    int prev, run, last, win, exp_tag;
    logic [31:0] exp_data;
    logic exp_cs;
    int kind;
    act[0] = 1'b0; act[1] = 1'b0;
    prev = -1; run = 0; last = 1; exp_tag = -1; exp_data = '0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && $urandom_range(0, 99) < 70) begin
          act[n] = 1'b1;
          kind = int'($urandom_range(0, 2));
          rd[n] = (kind != 1);
          wr[n] = (kind != 0);
          ad[n] = ($urandom_range(0, 9) == 0) ? 13'(DEPTH + $urandom_range(0, 100))
                                             : 13'(32'h100 + $urandom_range(0, 15));
          dt[n] = $urandom;
          be[n] = 4'($urandom_range(0, 15));
        end
        if (act[n]) drive(n, rd[n], wr[n], ad[n], dt[n], be[n]);
        else        drive(n, 1'b0, 1'b0, '0, '0, '0);
      end
      if (!act[0] && !act[1])      win = -1;
      else if (act[0] != act[1])   win = act[0] ? 0 : 1;
      else if (prev < 0)           win = 1 - last;
      else if (run >= BURST_MAX)   win = 1 - prev;
      else                         win = prev;
      exp_cs = (win >= 0) && (ad[win] < DEPTH);
      @(negedge clk);
      checks++; if (m0_if.waitrequest !== (win != 0)) begin errors++; $display("FAIL rnd_wait0 cyc%0d: got %b exp %b", i, m0_if.waitrequest, win != 0); end
      checks++; if (m1_if.waitrequest !== (win != 1)) begin errors++; $display("FAIL rnd_wait1 cyc%0d: got %b exp %b", i, m1_if.waitrequest, win != 1); end
      checks++; if (mem_chipselect !== exp_cs) begin errors++; $display("FAIL rnd_cs cyc%0d: got %b exp %b", i, mem_chipselect, exp_cs); end
      checks++; if (mem_write !== (exp_cs && wr[win])) begin errors++; $display("FAIL rnd_we cyc%0d: got %b exp %b", i, mem_write, exp_cs && wr[win]); end
      if (exp_cs) begin
        checks++; if (mem_address !== ad[win]) begin errors++; $display("FAIL rnd_addr cyc%0d: got %h exp %h", i, mem_address, ad[win]); end
      end
      checks++; if (m0_if.readdatavalid !== (exp_tag == 0) || m1_if.readdatavalid !== (exp_tag == 1)) begin
        errors++; $display("FAIL rnd_rdv cyc%0d: got m1=%b m0=%b exp tag %0d", i, m1_if.readdatavalid, m0_if.readdatavalid, exp_tag);
      end
      if (exp_tag >= 0) begin
        checks++; if ((exp_tag == 0 ? m0_if.readdata : m1_if.readdata) !== exp_data) begin
          errors++; $display("FAIL rnd_data cyc%0d: got %h exp %h", i, (exp_tag == 0 ? m0_if.readdata : m1_if.readdata), exp_data);
        end
      end
      exp_tag = -1;
      if (win >= 0) begin
        if (wr[win]) begin
          if (ad[win] < DEPTH) shadow[ad[win]] = merge_be(shadow[ad[win]], dt[win], be[win]);
        end else begin
          exp_tag  = win;
          exp_data = (ad[win] < DEPTH) ? shadow[ad[win]] : 32'h0;
        end
        act[win] = 1'b0;
        run  = (win == prev) ? run + 1 : 1;
        last = win;
      end
      prev = win;
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    checks++; if (m0_if.readdatavalid !== (exp_tag == 0) || m1_if.readdatavalid !== (exp_tag == 1)) begin
      errors++; $display("FAIL rnd_tail_rdv: got m1=%b m0=%b exp tag %0d", m1_if.readdatavalid, m0_if.readdatavalid, exp_tag);
    end
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i]    = (i * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
      shadow[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    end
    test_reset();
    test_write_read();
    test_round_robin();
    test_out_of_range();
    test_byte_write();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
